cur_mb_load: RTL and testbench
==============================

CUR_MB_LOAD -- requirements
Module: cur_mb_load

Interface
REQ-001 Parameter PIC_W_MB_LEN, default 8, width of MB column index and sys_x_total.
REQ-002 Parameter PIC_H_MB_LEN, default 8, width of MB row index.
REQ-003 Parameter ADDR_W, default 32, word address width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 sys_x_total  in  PIC_W_MB_LEN  last MB column index (MBs per row minus 1).
REQ-007 luma_base_i / cb_base_i / cr_base_i  in  ADDR_W each  frame plane base word addresses.
REQ-008 load_start_i  in  1  one-cycle start pulse from top_ctrl.
REQ-009 mb_x_i / mb_y_i  in  PIC_W_MB_LEN / PIC_H_MB_LEN  MB to load, sampled on load_start_i.
REQ-010 load_done_o  out  1  one-cycle pulse: MB fully written to buffer.
REQ-011 rd_req_o  out  1  external read request; rd_addr_o  out  ADDR_W  word address.
REQ-012 rd_ack_i  in  1  request accepted, rd_data_i valid same cycle; rd_data_i  in  32  four 8-bit pixels, pixel 0 in [7:0].
REQ-013 cmb_wr_en_o  out  1, cmb_wr_addr_o  out  7, cmb_wr_data_o  out  32  current-MB buffer write port.

Function
REQ-014 FSM states IDLE, CALC, LUMA, CB, CR, DONE; IDLE->CALC on load_start_i; CALC->LUMA after one cycle; LUMA->CB after 64th ack; CB->CR after 16th ack; CR->DONE after 16th ack; DONE->IDLE unconditionally.
REQ-015 CALC latches mb_x_i, mb_y_i and computes luma stride = (sys_x_total+1)*4 words, chroma stride = (sys_x_total+1)*2 words, zero-extended to ADDR_W.
REQ-016 Luma word k (row r=k>>2, col c=k&3): rd_addr_o = luma_base_i + (mb_y*16+r)*luma_stride + mb_x*4 + c.
REQ-017 Chroma word k (r=k>>1, c=k&1): rd_addr_o = plane_base + (mb_y*8+r)*chroma_stride + mb_x*2 + c.
REQ-018 Buffer addresses: luma 0-63, Cb 64-79, Cr 80-95, raster order within plane.
REQ-019 rd_req_o high in LUMA/CB/CR; rd_addr_o stable while rd_req_o high and rd_ack_i low; next address presented the cycle after ack (max one word per cycle).
REQ-020 cmb_wr_en_o = rd_ack_i && rd_req_o, combinational with rd_data_i passed through; cmb_wr_addr_o = current word index.
REQ-021 load_done_o asserted for exactly the cycle in DONE.
REQ-022 load_start_i in any state other than IDLE is ignored; no queueing.
REQ-023 rd_ack_i while rd_req_o low is ignored.
REQ-024 All arithmetic modulo 2^ADDR_W; no overflow detection.
REQ-025 Minimum latency start-to-done with ack every cycle: 2 + 96 + 1 cycles (luma only: 2 + 64 + 1).

Reset
REQ-026 rst forces IDLE, word counter 0, latched MB indices 0; load_done_o, rd_req_o, cmb_wr_en_o 0; rd_addr_o, cmb_wr_addr_o 0.
REQ-027 rst mid-transfer abandons the MB with no load_done_o; an ack in the reset cycle is not written.

Configuration
REQ-028 Macro CUR_MB_LOAD_CHROMA_EN defined: CB and CR states exist, 96 words per MB.
REQ-029 Not defined: LUMA->DONE after 64th ack, cb_base_i/cr_base_i unused, buffer addresses 64-95 never written.

Structure
REQ-030 FSM state encoding, per-plane word counts (64/16/16) and buffer base offsets (0/64/80) live in the shared enc_defines package.
REQ-031 One sub-module cur_mb_addr_gen: address computation from base, stride, MB indices, row, column; the top holds FSM and counters.

Verification
REQ-032 sys_x_total=3, mb=(0,0), luma_base=0x1000, ack every cycle -> first rd_addr 0x1000, word 4 at 0x1010, load_done_o at cycle 99 after start.
REQ-033 mb=(2,1), sys_x_total=3 -> first luma address luma_base+16*16+8; first Cb address cb_base+8*8+4.
REQ-034 Random ack stalls of 0-5 cycles -> address held during stalls, 96 writes with addresses 0..95 in order, one done pulse.
REQ-035 load_start_i re-pulsed during LUMA -> ignored, transfer completes unchanged.
REQ-036 rst asserted at word 30 -> outputs zero next cycle, no done; new start loads full MB correctly.
REQ-037 Build without CUR_MB_LOAD_CHROMA_EN -> 64 writes, done 67 cycles after start.

Source files
------------

// File: rtl/cur_mb_load_pkg.sv
// cur_mb_load_pkg: shared enc_defines package for the current-MB loader.
// Holds the loader FSM encoding, per-plane word counts and the buffer
// offsets of each plane inside the 96-word current-MB buffer.
package enc_defines;
    typedef enum logic [2:0] {ST_IDLE, ST_CALC, ST_LUMA, ST_CB, ST_CR, ST_DONE} state_t;
    localparam int LUMA_WORDS = 64;
    localparam int CB_WORDS = 16;
    localparam int CR_WORDS = 16;
    localparam logic [6:0] LUMA_OFS = 7'd0;
    localparam logic [6:0] CB_OFS = 7'd64;
    localparam logic [6:0] CR_OFS = 7'd80;
    localparam logic [6:0] LUMA_LAST = 7'(int'(LUMA_OFS) + LUMA_WORDS - 1);
    localparam logic [6:0] CB_LAST = 7'(int'(CB_OFS) + CB_WORDS - 1);
    localparam logic [6:0] CR_LAST = 7'(int'(CR_OFS) + CR_WORDS - 1);
endpackage

// File: rtl/cur_mb_addr_gen.sv
// cur_mb_addr_gen: word address of one word of a macroblock in a frame plane.
// Ports: base/stride (plane base and row stride in words), mb_x/mb_y (MB
// indices), row/col (word position inside the MB), luma (1: 16x4-word luma
// block, 0: 8x2-word chroma block), addr (resulting word address, mod 2^ADDR_W).
module cur_mb_addr_gen #(
    parameter int PIC_W_MB_LEN = 8,
    parameter int PIC_H_MB_LEN = 8,
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]       base,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [PIC_W_MB_LEN-1:0] mb_x,
    input  logic [PIC_H_MB_LEN-1:0] mb_y,
    input  logic [3:0]              row,
    input  logic [1:0]              col,
    input  logic                    luma,
    output logic [ADDR_W-1:0]       addr
);
    logic [ADDR_W-1:0] line;
    logic [ADDR_W-1:0] xofs;
    assign line = (luma ? ADDR_W'(mb_y) << 4 : ADDR_W'(mb_y) << 3) + ADDR_W'(row);
    assign xofs = (luma ? ADDR_W'(mb_x) << 2 : ADDR_W'(mb_x) << 1) + ADDR_W'(col);
    assign addr = base + line * stride + xofs;
endmodule

// File: rtl/cur_mb_load.sv
// cur_mb_load: fetches one macroblock (luma, optionally Cb/Cr) from frame
// memory into the current-MB buffer.
// Ports: clk/rst (sync active-high), sys_x_total (MBs per row minus 1),
// luma/cb/cr_base_i (plane bases), load_start_i + mb_x_i/mb_y_i (request),
// load_done_o (completion pulse), rd_req_o/rd_addr_o/rd_ack_i/rd_data_i
// (word read port), cmb_wr_en_o/cmb_wr_addr_o/cmb_wr_data_o (buffer write).
// Build option: define CUR_MB_LOAD_CHROMA_EN to also load Cb and Cr (96 words);
// otherwise only the 64 luma words are loaded.
module cur_mb_load
    import enc_defines::*;
#(
    parameter int PIC_W_MB_LEN = 8,
    parameter int PIC_H_MB_LEN = 8,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIC_W_MB_LEN-1:0] sys_x_total,
    input  logic [ADDR_W-1:0]       luma_base_i,
    input  logic [ADDR_W-1:0]       cb_base_i,
    input  logic [ADDR_W-1:0]       cr_base_i,
    input  logic                    load_start_i,
    input  logic [PIC_W_MB_LEN-1:0] mb_x_i,
    input  logic [PIC_H_MB_LEN-1:0] mb_y_i,
    output logic                    load_done_o,
    output logic                    rd_req_o,
    output logic [ADDR_W-1:0]       rd_addr_o,
    input  logic                    rd_ack_i,
    input  logic [31:0]             rd_data_i,
    output logic                    cmb_wr_en_o,
    output logic [6:0]              cmb_wr_addr_o,
    output logic [31:0]             cmb_wr_data_o
);
    state_t state, state_n;
    logic [6:0] cnt;
    logic [PIC_W_MB_LEN-1:0] mb_x;
    logic [PIC_H_MB_LEN-1:0] mb_y;
    logic [ADDR_W-1:0] luma_stride, chroma_stride, addr;
    logic luma, xfer, ack, last;

    assign luma = state == ST_LUMA;
    assign xfer = luma || state == ST_CB || state == ST_CR;
    // Outputs are gated by rst so an ack in the reset cycle is never written.
    assign rd_req_o = xfer && !rst;
    assign ack = rd_req_o && rd_ack_i;
    assign last = luma ? cnt == LUMA_LAST : state == ST_CB ? cnt == CB_LAST : cnt == CR_LAST;
    assign rd_addr_o = rd_req_o ? addr : '0;
    assign load_done_o = state == ST_DONE && !rst;
    assign cmb_wr_en_o = ack;
    assign cmb_wr_addr_o = cnt;
    assign cmb_wr_data_o = rd_data_i;

    // Chroma offsets 64 and 80 are 16-aligned, so cnt[3:0] is the word index
    // within the current chroma plane.
    cur_mb_addr_gen #(
        .PIC_W_MB_LEN(PIC_W_MB_LEN),
        .PIC_H_MB_LEN(PIC_H_MB_LEN),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .base(luma ? luma_base_i : state == ST_CB ? cb_base_i : cr_base_i),
        .stride(luma ? luma_stride : chroma_stride),
        .mb_x(mb_x),
        .mb_y(mb_y),
        .row(luma ? cnt[5:2] : {1'b0, cnt[3:1]}),
        .col(luma ? cnt[1:0] : {1'b0, cnt[0]}),
        .luma(luma),
        .addr(addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            mb_x <= '0;
            mb_y <= '0;
            luma_stride <= '0;
            chroma_stride <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && load_start_i) begin
                mb_x <= mb_x_i;
                mb_y <= mb_y_i;
            end
            if (state == ST_CALC) begin
                luma_stride <= (ADDR_W'(sys_x_total) + ADDR_W'(1)) << 2;
                chroma_stride <= (ADDR_W'(sys_x_total) + ADDR_W'(1)) << 1;
                cnt <= '0;
            end else if (ack) begin
                cnt <= cnt + 7'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: state_n = load_start_i ? ST_CALC : ST_IDLE;
            ST_CALC: state_n = ST_LUMA;
`ifdef CUR_MB_LOAD_CHROMA_EN
            ST_LUMA: state_n = (ack && last) ? ST_CB : ST_LUMA;
`else
            ST_LUMA: state_n = (ack && last) ? ST_DONE : ST_LUMA;
`endif
            ST_CB:   state_n = (ack && last) ? ST_CR : ST_CB;
            ST_CR:   state_n = (ack && last) ? ST_DONE : ST_CR;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cur_mb_load.sv
// tb_cur_mb_load: randomized self-checking bench for cur_mb_load.
module tb_cur_mb_load;
`ifdef CUR_MB_LOAD_CHROMA_EN
    localparam int TOTAL = 96;
`else
    localparam int TOTAL = 64;
`endif
    logic clk = 0;
    logic rst;
    logic [7:0] sys_x_total, mb_x_i, mb_y_i;
    logic [31:0] luma_base_i, cb_base_i, cr_base_i, rd_addr_o, rd_data_i, cmb_wr_data_o;
    logic load_start_i, load_done_o, rd_req_o, rd_ack_i, cmb_wr_en_o;
    logic [6:0] cmb_wr_addr_o;

    cur_mb_load dut (
        .clk(clk), .rst(rst), .sys_x_total(sys_x_total),
        .luma_base_i(luma_base_i), .cb_base_i(cb_base_i), .cr_base_i(cr_base_i),
        .load_start_i(load_start_i), .mb_x_i(mb_x_i), .mb_y_i(mb_y_i),
        .load_done_o(load_done_o), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o),
        .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i), .cmb_wr_en_o(cmb_wr_en_o),
        .cmb_wr_addr_o(cmb_wr_addr_o), .cmb_wr_data_o(cmb_wr_data_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, wr_count = 0, done_count = 0, done_cyc = 0, start_cyc = 0;
    int ack_mode = 0, stall = 0;
    logic [31:0] cap[96];

    // Reference model: 0 idle, 1 one setup cycle, 2 transferring, 3 done pulse.
    int phase = 0, idx = 0;
    logic [31:0] exp_addr[96];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void build(input logic [31:0] lb, cb, cr, input logic [7:0] sx, mx, my);
        logic [31:0] ls, cs;
        ls = (32'(sx) + 1) * 4;
        cs = (32'(sx) + 1) * 2;
        for (int k = 0; k < 64; k++)
            exp_addr[k] = lb + (32'(my) * 16 + k / 4) * ls + 32'(mx) * 4 + k % 4;
        for (int k = 0; k < 16; k++) begin
            exp_addr[64 + k] = cb + (32'(my) * 8 + k / 2) * cs + 32'(mx) * 2 + k % 2;
            exp_addr[80 + k] = cr + (32'(my) * 8 + k / 2) * cs + 32'(mx) * 2 + k % 2;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) phase = 0;
        else if (phase == 0) begin
            if (load_start_i) begin
                build(luma_base_i, cb_base_i, cr_base_i, sys_x_total, mb_x_i, mb_y_i);
                phase = 1;
            end
        end else if (phase == 1) begin
            phase = 2;
            idx = 0;
        end else if (phase == 2) begin
            if (rd_ack_i) idx++;
            if (idx == TOTAL) phase = 3;
        end else phase = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("wr_en_in_rst", 32'(cmb_wr_en_o), 0);
            chk("done_in_rst", 32'(load_done_o), 0);
        end else begin
            chk("rd_req", 32'(rd_req_o), 32'(phase == 2));
            if (phase == 2) chk("rd_addr", rd_addr_o, exp_addr[idx]);
            chk("wr_en", 32'(cmb_wr_en_o), 32'(phase == 2 && rd_ack_i));
            if (cmb_wr_en_o) begin
                chk("wr_addr", 32'(cmb_wr_addr_o), 32'(idx));
                chk("wr_data", cmb_wr_data_o, rd_data_i);
                cap[cmb_wr_addr_o] = rd_addr_o;
                wr_count++;
            end
            chk("done", 32'(load_done_o), 32'(phase == 3));
            if (load_done_o) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rd_data_i = $urandom;
        if (ack_mode == 0) rd_ack_i = 1'b1;
        else if (stall == 0) begin
            rd_ack_i = 1'b1;
            stall = $urandom_range(0, 5);
        end else begin
            rd_ack_i = 1'b0;
            stall--;
        end
    end

    task automatic start_mb(input logic [7:0] x, y);
        @(posedge clk);
        #1;
        mb_x_i = x;
        mb_y_i = y;
        load_start_i = 1'b1;
        start_cyc = cyc;
        wr_count = 0;
        @(posedge clk);
        #1;
        load_start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_count == d0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("done_pulses", 32'(done_count - d0), 1);
        chk("write_count", 32'(wr_count), 32'(TOTAL));
    endtask

    initial begin
        int d0, n;
        rst = 1'b1;
        load_start_i = 0;
        mb_x_i = 0;
        mb_y_i = 0;
        sys_x_total = 0;
        luma_base_i = 0;
        cb_base_i = 0;
        cr_base_i = 0;
        rd_ack_i = 0;
        rd_data_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(rd_req_o), 0);
        chk("rst_addr", rd_addr_o, 0);
        chk("rst_wr_en", 32'(cmb_wr_en_o), 0);
        chk("rst_wr_addr", 32'(cmb_wr_addr_o), 0);
        chk("rst_done", 32'(load_done_o), 0);

        sys_x_total = 3;
        luma_base_i = 32'h1000;
        cb_base_i = 32'h2000;
        cr_base_i = 32'h3000;
        ack_mode = 0;
        d0 = done_count;
        start_mb(0, 0);
        wait_done(d0);
        chk("first_luma_addr", cap[0], 32'h1000);
        chk("word4_addr", cap[4], 32'h1010);
        chk("done_latency", 32'(done_cyc - start_cyc), 32'(TOTAL + 2));

        ack_mode = 1;
        d0 = done_count;
        start_mb(2, 1);
        wait_done(d0);
        chk("mb21_luma_addr", cap[0], 32'h1000 + 264);
`ifdef CUR_MB_LOAD_CHROMA_EN
        chk("mb21_cb_addr", cap[64], 32'h2000 + 68);
`endif

        for (int t = 0; t < 6; t++) begin
            sys_x_total = 8'($urandom_range(0, 40));
            luma_base_i = $urandom;
            cb_base_i = $urandom;
            cr_base_i = $urandom;
            ack_mode = t % 2;
            d0 = done_count;
            start_mb(8'($urandom_range(0, int'(sys_x_total))), 8'($urandom));
            wait_done(d0);
        end

        ack_mode = 1;
        d0 = done_count;
        start_mb(1, 2);
        n = 0;
        while (wr_count < 10 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        load_start_i = 1'b1;
        mb_x_i = 3;
        mb_y_i = 0;
        @(posedge clk);
        #1 load_start_i = 1'b0;
        wait_done(d0);

        d0 = done_count;
        start_mb(2, 3);
        n = 0;
        while (wr_count < 30 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("reached_word30", 32'(wr_count >= 30), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(rd_req_o), 0);
        chk("post_rst_addr", rd_addr_o, 0);
        repeat (150) @(posedge clk);
        chk("no_done_after_rst", 32'(done_count - d0), 0);
        d0 = done_count;
        start_mb(0, 1);
        wait_done(d0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
